// File: rtl/word_fifo16_pkg.sv
// Shared types and constants for the word_fifo16 buffer.
package word_fifo16_pkg;

  // Datapath word width, common to the CPU datapath.
  localparam int unsigned WORD_W = 16;

  // Default number of entries.
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;

  // Pointer increment with natural power-of-two wrap.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/word_fifo16_if.sv
// Handshake and status bundle between a word producer/reader and word_fifo16.
interface word_fifo16_if
  import word_fifo16_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clear;
  logic             in_valid;
  word_t            in_data;
  logic             in_ready;
  logic             out_valid;
  word_t            out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // Environment side: drives words in and consumes them.
  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty
  );

  // Buffer side.
  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty
  );

endinterface

// File: rtl/word_fifo16_regfile.sv
// DEPTH x WORD_W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module word_regfile
  import word_fifo16_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  word_t            i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output word_t            o_rdata
);

  word_t r_mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/word_fifo16.sv
// Registered first-word-fall-through 16-bit word buffer with valid/ready on both
// sides. Full/empty come from the occupancy count, not from pointer compare.
module word_fifo16
  import word_fifo16_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  word_fifo16_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic  w_full;
  logic  w_empty;
  logic  w_in_ready;
  logic  w_out_valid;
  logic  w_push;
  logic  w_pop;
  word_t w_rdata;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_in_ready  = !w_full && !bus.clear;
  assign w_out_valid = !w_empty && !bus.clear;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // Next pointer/count: clear wins, otherwise advance on push and/or pop.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (bus.clear) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        w_count_nxt = r_count - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  word_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  // Gate the head word so unwritten storage never leaks X downstream.
  assign bus.out_data  = w_out_valid ? w_rdata : '0;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;

endmodule
